display_scan_controller: RTL



---
 rtl/display_scan_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexes an 8-digit seven-segment display. Each digit owns a
//   fixed slot of REFRESH_DIV cycles. The slot opens with BLANK_CYCLES of
//   all-anodes-off, which lets the nibble mux and decoder settle after sel
//   moves. The remainder of the slot drives that digit's anode if its
//   digit_en bit is set.
//
//   Ports
//     clk        system clock, rising edge
//     reset      synchronous, active-high
//     enable     1 = scan runs, 0 = dark display, digit position held
//     digit_en   per-digit enable mask, bit n = digit n
//     sel        registered digit select to the 8:1 nibble mux
//     anode      registered active-low anode drive, at most one bit low
//     scan_tick  one-cycle pulse on the cycle sel advances
module display_scan_controller #(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = $clog2(REFRESH_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] digit_en,
  output logic [2:0] sel,
  output logic [7:0] anode,
  output logic       scan_tick
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       anode_q, anode_d;
  logic             tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    anode_d = 8'hFF;

    if (!enable) begin
      // Dropping enable parks the scan; the slot restarts from BLANK later.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            // Slot boundary: sel moves on the same edge that enters BLANK,
            // so the mux path settles while the anodes are dark.
            state_d = BLANK;
            cnt_d   = '0;
            sel_d   = sel_q + 3'd1;
            tick_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Anode is derived from the next state so the registered output lines
    // up with the state it belongs to; the mask is sampled every cycle.
    if (state_d == SHOW && digit_en[sel_d]) begin
      anode_d = ~(8'b1 << sel_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      anode_q <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  assign sel       = sel_q;
  assign anode     = anode_q;
  assign scan_tick = tick_q;

endmodule
